// File: rtl/pico_master.sv
// ---------------------------------------------------------------------------
// pico_master
//
// Bridges a valid/ready command/response pair onto a simple single-beat
// memory bus (valid/ready with byte strobes). At most one transaction is in
// flight at a time. A transaction moves through three states:
//   IDLE : cmd_ready high; a command is latched as soon as cmd_valid is seen
//   BUS  : mem_valid high with the latched address/data/strobes held steady
//          until the slave answers with mem_ready or the wait budget runs out
//   RESP : resp_valid high with the result held until resp_ready
//
// Peak throughput is one transaction every three cycles.
//
// Parameters
//   ADDR_W  : width of cmd_addr / mem_addr
//   TIMEOUT : BUS cycles tolerated without mem_ready before an error
//             response (0..255, 0 disables the timeout)
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   cmd_valid / cmd_ready    : command handshake
//   cmd_we, cmd_wstrb,
//   cmd_addr, cmd_wdata      : command payload (strobes ignored for reads)
//   resp_valid / resp_ready  : response handshake
//   resp_rdata, resp_err     : read data (0 for writes/errors), timeout flag
//   mem_valid, mem_wstrb,
//   mem_addr, mem_wdata      : bus request toward the slave
//   mem_ready, mem_rdata     : slave completion and read data
// ---------------------------------------------------------------------------
module pico_master #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [3:0]        cmd_wstrb,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,

  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,

  output logic              mem_valid,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT);
  localparam bit         TIMEOUT_EN    = (TIMEOUT != 0);

  state_t     state;
  logic [7:0] wait_cnt;
  // Remembers the direction separately: a write with all strobes clear must
  // still answer with zero data, so mem_wstrb alone cannot tell reads apart.
  logic       is_write;

  // All outputs are registers updated together with the state, so each
  // handshake signal is a clean flop output with no decode logic behind it.
  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // register in this block sees the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      mem_valid  <= 1'b0;
      mem_wstrb  <= 4'h0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      wait_cnt   <= 8'h0;
      is_write   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            mem_addr  <= cmd_addr;
            mem_wdata <= cmd_wdata;
            // Reads never drive byte enables onto the bus.
            mem_wstrb <= cmd_we ? cmd_wstrb : 4'h0;
            is_write  <= cmd_we;
            wait_cnt  <= 8'h0;
            cmd_ready <= 1'b0;
            mem_valid <= 1'b1;
            state     <= BUS;
          end
        end

        BUS: begin
          // Completion is tested first so a mem_ready arriving in the very
          // cycle the timeout would fire still yields a good response.
          if (mem_ready) begin
            resp_rdata <= is_write ? 32'h0 : mem_rdata;
            resp_err   <= 1'b0;
            mem_valid  <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (TIMEOUT_EN && (wait_cnt == TIMEOUT_LIMIT)) begin
            resp_rdata <= 32'h0;
            resp_err   <= 1'b1;
            mem_valid  <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            // Free-running 8-bit count; wrapping only matters with the
            // timeout disabled, where the value is never compared.
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            cmd_ready  <= 1'b1;
            state      <= IDLE;
          end
        end

        // NOTE: the unused encoding (2'd3) is steered back to a clean IDLE so
        // a corrupted state register cannot lock the bridge up.
        default: begin
          state      <= IDLE;
          cmd_ready  <= 1'b1;
          mem_valid  <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pico_master.sv
// ---------------------------------------------------------------------------
// tb_pico_master
//
// Drives pico_master against a behavioural pico_slave (six 32-bit byte-
// strobed registers at addresses 0..5, programmable wait states, optional
// "never answer" mode, random noise on mem_ready/mem_rdata outside BUS).
// Expected responses are computed from a separate register model when a
// command is accepted, pushed to a queue, and popped/compared when the DUT
// completes a response handshake.
// ---------------------------------------------------------------------------
module tb_pico_master;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [3:0]        cmd_wstrb;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_valid;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  pico_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_wstrb  (cmd_wstrb),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_valid  (mem_valid),
    .mem_wstrb  (mem_wstrb),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t             sb_q[$];
  int                n_checks = 0;
  int                n_errors = 0;
  int                n_sent   = 0;
  int                n_resp   = 0;
  int                mv_cycles = 0;

  logic [31:0]       sb_mem  [0:5];   // expected register contents
  logic [31:0]       slv_regs[0:5];   // slave's actual storage
  int                slave_wait;
  bit                slave_hold;
  bit                rr_random;
  int                wcnt;

  logic [ADDR_W-1:0] exp_addr;
  logic [31:0]       exp_wdata;
  logic [3:0]        exp_wstrb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural slave: drives mem_ready/mem_rdata one step after each rising
  // edge; answers after slave_wait extra BUS cycles.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    wcnt      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_valid && !slave_hold) begin
        if (wcnt >= slave_wait) begin
          mem_ready = 1'b1;
          if (mem_wstrb == 4'h0) begin
            mem_rdata = slv_regs[mem_addr];
          end else begin
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) slv_regs[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
            mem_rdata = $urandom;
          end
          wcnt = 0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          wcnt++;
        end
      end else begin
        // Noise outside BUS must be ignored by the master.
        mem_ready = mem_valid ? 1'b0 : 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        if (!mem_valid) wcnt = 0;
      end
    end
  end

  // Random response backpressure, enabled for the mixed traffic phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_random) resp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: bus payload stability and response scoreboard.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_valid) begin
          mv_cycles++;
          check("mem_addr",  32'(mem_addr),  32'(exp_addr));
          check("mem_wdata", mem_wdata,      exp_wdata);
          check("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
        end
        if (resp_valid && resp_ready) begin
          if (sb_q.size() == 0) begin
            check("resp_extra", 32'(sb_q.size()), 32'd1);
          end else begin
            e = sb_q.pop_front();
            check("resp_rdata", resp_rdata,      e.rdata);
            check("resp_err",   32'(resp_err),   32'(e.err));
            n_resp++;
          end
        end
      end
    end
  end

  // Issue one command (called one step after a rising edge); returns one step
  // after the accepting edge, i.e. in the first BUS cycle.
  task automatic send(input bit we, input logic [ADDR_W-1:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wstrb,
                      input bit exp_err);
    resp_t e;
    int    n;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wstrb = wstrb;
    cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 200);
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    e.err   = exp_err;
    e.rdata = 32'h0;
    if (!exp_err) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) sb_mem[addr][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        e.rdata = sb_mem[addr];
      end
    end
    exp_addr  = addr;
    exp_wdata = wdata;
    exp_wstrb = we ? wstrb : 4'h0;
    sb_q.push_back(e);
    n_sent++;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected response has been seen and the
  // master is idle again; returns one step after a rising edge.
  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || !cmd_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_bound", 32'(n < 500), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_we     = 1'b0;
    cmd_wstrb  = 4'h0;
    cmd_addr   = '0;
    cmd_wdata  = 32'h0;
    resp_ready = 1'b0;
    slave_wait = 0;
    slave_hold = 1'b0;
    rr_random  = 1'b0;
    exp_addr   = '0;
    exp_wdata  = 32'h0;
    exp_wstrb  = 4'h0;
    for (int a = 0; a < 6; a++) begin
      sb_mem[a]   = 32'h0;
      slv_regs[a] = 32'h0;
    end
    sb_mem[4]   = 32'h0000_005A;
    slv_regs[4] = 32'h0000_005A;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready",  32'(cmd_ready),  32'd1);
    check("rst_mem_valid",  32'(mem_valid),  32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err",   32'(resp_err),   32'd0);
    check("rst_resp_rdata", resp_rdata,      32'h0);
    check("rst_mem_addr",   32'(mem_addr),   32'd0);
    check("rst_mem_wdata",  mem_wdata,       32'h0);
    check("rst_mem_wstrb",  32'(mem_wstrb),  32'd0);
    @(posedge clk);
    #1;

    // Write, slave ready in the first BUS cycle
    resp_ready = 1'b1;
    slave_wait = 0;
    mv_cycles  = 0;
    send(1'b1, 8'h02, 32'h0000_00A5, 4'hF, 1'b0);
    @(negedge clk);
    check("wr_mem_valid", 32'(mem_valid), 32'd1);
    @(negedge clk);
    check("wr_mem_valid_low", 32'(mem_valid),  32'd0);
    check("wr_resp_valid",    32'(resp_valid), 32'd1);
    wait_idle();
    check("wr_mv_cycles", 32'(mv_cycles), 32'd1);

    // Read with three wait states
    slave_wait = 3;
    mv_cycles  = 0;
    send(1'b0, 8'h04, 32'hFFFF_FFFF, 4'hF, 1'b0);
    wait_idle();
    check("rd_mv_cycles", 32'(mv_cycles), 32'd4);

    // Timeout: slave never answers
    slave_hold = 1'b1;
    mv_cycles  = 0;
    send(1'b0, 8'h01, 32'h0, 4'h0, 1'b1);
    wait_idle();
    check("to_mv_cycles", 32'(mv_cycles), 32'd16);

    // Completion on the 16th BUS cycle beats the timeout
    slave_hold = 1'b0;
    slave_wait = 15;
    mv_cycles  = 0;
    send(1'b0, 8'h04, 32'h0, 4'h0, 1'b0);
    wait_idle();
    check("to_edge_mv_cycles", 32'(mv_cycles), 32'd16);

    // Backpressure on the response channel
    slave_wait = 0;
    resp_ready = 1'b0;
    send(1'b0, 8'h04, 32'h0, 4'h0, 1'b0);
    n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_resp_seen", 32'(resp_valid), 32'd1);
    @(posedge clk);
    #1;
    cmd_we    = 1'b1;
    cmd_addr  = 8'h03;
    cmd_wdata = 32'h1122_3344;
    cmd_wstrb = 4'hF;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_resp_rdata", resp_rdata,      32'h0000_005A);
      check("bp_cmd_ready",  32'(cmd_ready),  32'd0);
      check("bp_mem_valid",  32'(mem_valid),  32'd0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    send(1'b1, 8'h03, 32'h1122_3344, 4'hF, 1'b0);
    wait_idle();
    send(1'b0, 8'h03, 32'h0, 4'h0, 1'b0);
    wait_idle();

    // Asynchronous reset in the middle of BUS
    slave_hold = 1'b1;
    send(1'b0, 8'h05, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("ar_mem_valid_before", 32'(mem_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_mem_valid_async",  32'(mem_valid),  32'd0);
    check("ar_resp_valid_async", 32'(resp_valid), 32'd0);
    sb_q.delete();
    n_sent--;
    @(posedge clk);
    #2;
    rst        = 1'b0;
    slave_hold = 1'b0;
    slave_wait = 1;
    @(negedge clk);
    check("ar_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ar_no_resp", 32'(resp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(1'b1, 8'h05, 32'hDEAD_BEEF, 4'h5, 1'b0);
    wait_idle();
    send(1'b0, 8'h05, 32'h0, 4'h0, 1'b0);
    wait_idle();

    // Random read/write mix with random response backpressure
    rr_random = 1'b1;
    for (int t = 0; t < 60; t++) begin
      slave_wait = $urandom_range(0, 4);
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 5)), $urandom,
           4'($urandom_range(0, 15)), 1'b0);
    end
    rr_random  = 1'b0;
    resp_ready = 1'b1;
    wait_idle();
    for (int a = 0; a < 6; a++) begin
      send(1'b0, 8'(a), 32'h0, 4'h0, 1'b0);
      wait_idle();
    end
    check("txn_count", 32'(n_resp), 32'(n_sent));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pico_master.md
PICO_MASTER -- requirements
Module: pico_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, address width matching the slave-side addr port.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, range 0..255, the number of BUS cycles allowed without mem_ready before an error response (0 = no timeout).
REQ-003 The block SHALL have port clk  in  1  sole clock, all state updates on the rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port cmd_valid  in  1  command request.
REQ-006 The block SHALL have port cmd_ready  out  1  command accepted this cycle when high with cmd_valid.
REQ-007 The block SHALL have port cmd_we  in  1  1 = write, 0 = read.
REQ-008 The block SHALL have port cmd_wstrb  in  4  byte write enables.
REQ-009 The block SHALL have port cmd_addr  in  ADDR_W  target address.
REQ-010 The block SHALL have port cmd_wdata  in  32  write data.
REQ-011 The block SHALL have port resp_valid  out  1  response available.
REQ-012 The block SHALL have port resp_ready  in  1  response consumed when high with resp_valid.
REQ-013 The block SHALL have port resp_rdata  out  32  read data (0 for writes and errors).
REQ-014 The block SHALL have port resp_err  out  1  1 = transaction timed out.
REQ-015 The block SHALL have ports mem_valid out 1, mem_wstrb out 4, mem_addr out ADDR_W, mem_wdata out 32: bus request toward the slave.
REQ-016 The block SHALL have ports mem_ready in 1, mem_rdata in 32: slave completion and read data.

Function
REQ-017 The FSM SHALL have states IDLE, BUS, RESP; cmd_ready = 1 only in IDLE; one transaction outstanding at most.
REQ-018 In IDLE with cmd_valid = 1, the block SHALL latch cmd_addr, cmd_wdata and cmd_wstrb (wstrb forced to 0 when cmd_we = 0), clear the wait counter and enter BUS.
REQ-019 In BUS, mem_valid SHALL be 1 and mem_addr/mem_wdata/mem_wstrb SHALL be held constant from the latched command; outside BUS mem_valid SHALL be 0.
REQ-020 In BUS with mem_ready = 1, the block SHALL capture mem_rdata into resp_rdata for reads (0 for writes), clear resp_err and enter RESP.
REQ-021 In BUS with mem_ready = 0, the 8-bit wait counter SHALL increment; when TIMEOUT != 0 and the counter equals TIMEOUT at a cycle with mem_ready = 0, the block SHALL set resp_err = 1, resp_rdata = 0 and enter RESP.
REQ-022 If mem_ready = 1 in the cycle the timeout would fire, completion SHALL win (resp_err = 0).
REQ-023 In RESP, resp_valid SHALL be 1 with resp_rdata/resp_err stable until resp_ready = 1, then the block SHALL return to IDLE.
REQ-024 mem_ready and mem_rdata SHALL be ignored outside BUS.
REQ-025 Latency: command accepted at edge N -> mem_valid high in cycle N+1; mem_ready in cycle N+k -> resp_valid high in cycle N+k+1; back-to-back peak throughput one transaction per 3 cycles.

Reset
REQ-026 Assertion of rst SHALL immediately (no clock) force IDLE, mem_valid = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_addr/mem_wdata/mem_wstrb = 0, wait counter = 0.
REQ-027 Reset during BUS or RESP SHALL abandon the transaction without a response; cmd_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-028 Write: cmd addr 0x02, wdata 0x000000A5, wstrb 0xF, we 1; slave ready 1 cycle later -> mem_valid for exactly 1 cycle with those values, resp_valid next cycle, resp_err 0, resp_rdata 0.
REQ-029 Read: cmd addr 0x04, we 1'b0, wstrb 0xF; slave returns mem_rdata 0x0000005A after 3 wait cycles -> mem_wstrb 0 throughout, resp_rdata 0x0000005A, resp_err 0.
REQ-030 Timeout: TIMEOUT 15, mem_ready held 0 -> resp_valid with resp_err 1 and resp_rdata 0 after 16 BUS cycles; mem_ready arriving on the 16th BUS cycle -> resp_err 0.
REQ-031 Backpressure: resp_ready held 0 for 5 cycles -> resp_valid/resp_rdata stable, cmd_ready 0, new cmd_valid not accepted until after handshake.
REQ-032 Async reset: rst pulsed mid-BUS between clock edges -> mem_valid falls without a clock edge, no response issued, next command proceeds normally.
REQ-033 Random read/write mix against the pico_slave register map (addr 0..5) -> rw registers read back last written byte, no dropped or duplicated transactions.
